// File: rtl/subservient_timer_pkg.sv
// Shared register map, CTRL/STATUS field layout and byte-lane merge helper
// for the Wishbone machine timer.
package subservient_timer_pkg;

   localparam logic [1:0] REG_MTIME    = 2'd0;
   localparam logic [1:0] REG_MTIMECMP = 2'd1;
   localparam logic [1:0] REG_CTRL     = 2'd2;
   localparam logic [1:0] REG_STATUS   = 2'd3;

   localparam int CTRL_ENABLE_BIT   = 0;
   localparam int CTRL_IRQ_EN_BIT   = 1;
   localparam int CTRL_PRESCALE_LSB = 8;
   localparam int CTRL_PRESCALE_W   = 8;
   localparam int STATUS_MATCH_BIT  = 0;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] wr_val,
                                              input logic [3:0]  sel);
      byte_merge = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) byte_merge[8*b +: 8] = wr_val[8*b +: 8];
      end
   endfunction

endpackage

// File: rtl/subservient_timer_prescaler.sv
// Prescale counter: counts 0..prescale while enabled and emits a one-cycle
// tick on the terminal count.
module subservient_timer_prescaler
   import subservient_timer_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [CTRL_PRESCALE_W-1:0] prescale,
   input  logic                       clear,
   output logic                       tick
);

   logic [CTRL_PRESCALE_W-1:0] cnt_reg;
   logic [CTRL_PRESCALE_W-1:0] cnt_next;

   assign tick = enable & (cnt_reg == prescale);

   always_comb begin
      cnt_next = cnt_reg + CTRL_PRESCALE_W'(1);
      if (clear || !enable || tick) cnt_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_reg <= '0;
      else        cnt_reg <= cnt_next;
   end

endmodule

// File: rtl/subservient_wb_timer.sv
// Wishbone-attached machine timer: MTIME/MTIMECMP/CTRL/STATUS registers with
// a prescaled MTIME increment and a registered level interrupt.
module subservient_wb_timer
   import subservient_timer_pkg::*;
#(
   parameter logic [7:0]  DEFAULT_PRESCALE = 8'd0,
   parameter logic [31:0] CMP_RESET        = 32'hFFFF_FFFF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_stb,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_timer_irq
);

   logic [31:0] mtime_reg, mtime_next;
   logic [31:0] cmp_reg, cmp_next;
   logic [31:0] rdt_reg, rdt_next;
   logic [CTRL_PRESCALE_W-1:0] prescale_reg, prescale_next;
   logic        enable_reg, enable_next;
   logic        irq_en_reg, irq_en_next;
   logic        ack_reg, ack_next;
   logic        irq_reg, irq_next;
   logic        access, wr_en, tick, presc_clear;
   logic [1:0]  reg_idx;
   logic [31:0] ctrl_word, ctrl_wr, status_word;
   logic        unused_bits;

   assign reg_idx = i_wb_adr[3:2];
   assign access  = i_wb_stb & ~ack_reg;
   assign wr_en   = access & i_wb_we;

   always_comb begin
      ctrl_word = '0;
      ctrl_word[CTRL_ENABLE_BIT] = enable_reg;
      ctrl_word[CTRL_IRQ_EN_BIT] = irq_en_reg;
      ctrl_word[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W] = prescale_reg;
      status_word = '0;
      status_word[STATUS_MATCH_BIT] = (mtime_reg >= cmp_reg);
   end

   assign ctrl_wr     = byte_merge(ctrl_word, i_wb_dat, i_wb_sel);
   assign unused_bits = ^{ctrl_wr[31:16], ctrl_wr[7:2], i_wb_adr[31:4], i_wb_adr[1:0]};

   // A bus write to MTIME overrides a same-cycle tick increment.
   always_comb begin
      mtime_next    = tick ? mtime_reg + 32'd1 : mtime_reg;
      cmp_next      = cmp_reg;
      enable_next   = enable_reg;
      irq_en_next   = irq_en_reg;
      prescale_next = prescale_reg;
      if (wr_en) begin
         case (reg_idx)
            REG_MTIME:    mtime_next = byte_merge(mtime_reg, i_wb_dat, i_wb_sel);
            REG_MTIMECMP: cmp_next   = byte_merge(cmp_reg, i_wb_dat, i_wb_sel);
            REG_CTRL: begin
               enable_next   = ctrl_wr[CTRL_ENABLE_BIT];
               irq_en_next   = ctrl_wr[CTRL_IRQ_EN_BIT];
               prescale_next = ctrl_wr[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W];
            end
            default: ;
         endcase
      end
      presc_clear = (enable_next != enable_reg) | (prescale_next != prescale_reg);
   end

   always_comb begin
      ack_next = access;
      rdt_next = rdt_reg;
      if (access) begin
         case (reg_idx)
            REG_MTIME:    rdt_next = mtime_reg;
            REG_MTIMECMP: rdt_next = cmp_reg;
            REG_CTRL:     rdt_next = ctrl_word;
            default:      rdt_next = status_word;
         endcase
      end
      irq_next = irq_en_next & (mtime_next >= cmp_next);
   end

   subservient_timer_prescaler u_prescaler (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .enable   (enable_reg),
      .prescale (prescale_reg),
      .clear    (presc_clear),
      .tick     (tick)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mtime_reg    <= '0;
         cmp_reg      <= CMP_RESET;
         enable_reg   <= 1'b0;
         irq_en_reg   <= 1'b0;
         prescale_reg <= DEFAULT_PRESCALE;
         ack_reg      <= 1'b0;
         rdt_reg      <= '0;
         irq_reg      <= 1'b0;
      end else begin
         mtime_reg    <= mtime_next;
         cmp_reg      <= cmp_next;
         enable_reg   <= enable_next;
         irq_en_reg   <= irq_en_next;
         prescale_reg <= prescale_next;
         ack_reg      <= ack_next;
         rdt_reg      <= rdt_next;
         irq_reg      <= irq_next;
      end
   end

   assign o_wb_ack    = ack_reg;
   assign o_wb_rdt    = rdt_reg;
   assign o_timer_irq = irq_reg;

endmodule

// File: tb/tb_subservient_wb_timer.sv
// Directed bench for subservient_wb_timer; expected values are cycle-counted
// by hand from the bus handshake and prescaler timing.
module tb_subservient_wb_timer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wb_adr = '0;
   logic [31:0] wb_dat = '0;
   logic [3:0]  wb_sel = '0;
   logic        wb_we = 1'b0;
   logic        wb_stb = 1'b0;
   logic [31:0] wb_rdt;
   logic        wb_ack;
   logic        timer_irq;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic irq_at_ack;

   always #5 clk = ~clk;

   subservient_wb_timer dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_wb_adr    (wb_adr),
      .i_wb_dat    (wb_dat),
      .i_wb_sel    (wb_sel),
      .i_wb_we     (wb_we),
      .i_wb_stb    (wb_stb),
      .o_wb_rdt    (wb_rdt),
      .o_wb_ack    (wb_ack),
      .o_timer_irq (timer_irq)
   );

   // One transaction: ack edge A, stb dropped, returns #1 after edge A+1.
   task automatic bus(input logic we, input logic [1:0] idx, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
      int n;
      wb_adr = {28'h4000000, idx, 2'b00};
      wb_dat = dat;
      wb_sel = sel;
      wb_we  = we;
      wb_stb = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!wb_ack && n < 4);
      if (!wb_ack) begin
         n_cmp++; n_bad++;
         $display("FAIL bus_timeout idx=%0d ack=%b want 1", idx, wb_ack);
      end
      rd = wb_rdt;
      irq_at_ack = timer_irq;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [1:0] idx, input logic [31:0] dat);
      logic [31:0] dummy;
      bus(1'b1, idx, dat, 4'hF, dummy);
      $display("write idx=%0d data=%h", idx, dat);
   endtask

   task automatic rd(input logic [1:0] idx, output logic [31:0] val);
      bus(1'b0, idx, 32'h0, 4'h0, val);
      $display("read  idx=%0d data=%h", idx, val);
   endtask

   task automatic do_reset;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      do_reset();
      n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", wb_ack); end
      n_cmp++; if (wb_rdt !== 32'h0) begin n_bad++; $display("FAIL reset_rdt got %h want 00000000", wb_rdt); end
      n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", timer_irq); end
      rd(2'd0, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_mtime got %h want 00000000", v); end
      rd(2'd1, v);
      n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_mtimecmp got %h want ffffffff", v); end
      rd(2'd2, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got %h want 00000000", v); end
      rd(2'd3, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_status got %h want 00000000", v); end
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd3, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL status_ro got %h want 00000000", v); end
      n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq_after got %b want 0", timer_irq); end
   endtask

   task automatic test_ctrl_mask;
      logic [31:0] v;
      do_reset();
      wr(2'd2, 32'hFFFF_FFFC);
      rd(2'd2, v);
      n_cmp++; if (v !== 32'h0000_FF00) begin n_bad++; $display("FAIL ctrl_mask got %h want 0000ff00", v); end
   endtask

   task automatic test_reset_midcycle;
      logic saw_ack;
      do_reset();
      saw_ack = 1'b0;
      @(negedge clk);
      wb_adr = 32'h0; wb_we = 1'b0; wb_stb = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         saw_ack = saw_ack | wb_ack;
      end
      wb_stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         saw_ack = saw_ack | wb_ack;
      end
      n_cmp++; if (saw_ack !== 1'b0) begin n_bad++; $display("FAIL midreset_ack got %b want 0", saw_ack); end
      n_cmp++; if (wb_rdt !== 32'h0) begin n_bad++; $display("FAIL midreset_rdt got %h want 00000000", wb_rdt); end
      $display("midcycle reset ack_seen=%b", saw_ack);
   endtask

   task automatic test_back_to_back;
      logic [3:0]  pat;
      logic [31:0] first;
      do_reset();
      wb_adr = 32'h0000_0004; wb_we = 1'b0; wb_stb = 1'b1;
      first = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pat[i] = wb_ack;
         if (i == 0) first = wb_rdt;
      end
      wb_stb = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (pat !== 4'b0101) begin n_bad++; $display("FAIL b2b_ack_pattern got %b want 0101", pat); end
      n_cmp++; if (first !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL b2b_rdt got %h want ffffffff", first); end
      n_cmp++; if (wb_rdt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL b2b_rdt_hold got %h want ffffffff", wb_rdt); end
      $display("back-to-back ack pattern=%b", pat);
   endtask

   task automatic test_enable;
      logic [31:0] v;
      do_reset();
      wr(2'd2, 32'h0000_0001);       // ack edge W
      repeat (9) @(posedge clk); #1; // read acks at W+11
      rd(2'd0, v);
      n_cmp++; if (v !== 32'd10) begin n_bad++; $display("FAIL enable_count got %0d want 10", v); end
   endtask

   task automatic test_prescale;
      logic [31:0] v;
      do_reset();
      wr(2'd2, 32'h0000_0301);        // ack edge W
      repeat (39) @(posedge clk); #1; // read acks at W+41
      rd(2'd0, v);
      n_cmp++; if (v !== 32'd10) begin n_bad++; $display("FAIL prescale3_count got %0d want 10", v); end
      wr(2'd2, 32'h0000_0501);        // ack edge X = W+43, counter restarts
      repeat (4) @(posedge clk); #1;  // read acks at X+6
      rd(2'd0, v);
      n_cmp++; if (v !== 32'd10) begin n_bad++; $display("FAIL prescale_restart got %0d want 10", v); end
      rd(2'd0, v);                    // acks at X+8
      n_cmp++; if (v !== 32'd11) begin n_bad++; $display("FAIL prescale5_tick got %0d want 11", v); end
   endtask

   task automatic test_wrap;
      logic [31:0] v;
      do_reset();
      wr(2'd0, 32'hFFFF_FFFE);
      wr(2'd2, 32'h0000_0001);        // ticks at W+1, W+2
      wr(2'd2, 32'h0000_0000);        // acks at W+2, freezes after second tick
      rd(2'd0, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL wrap_value got %h want 00000000", v); end
      rd(2'd0, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL frozen_value got %h want 00000000", v); end
   endtask

   task automatic test_irq;
      logic [31:0] v;
      do_reset();
      wr(2'd1, 32'd5);
      wr(2'd2, 32'h0000_0003);        // ack edge W, MTIME=k after W+k
      repeat (3) @(posedge clk); #1;
      n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL irq_early got %b want 0", timer_irq); end
      @(posedge clk); #1;
      n_cmp++; if (timer_irq !== 1'b1) begin n_bad++; $display("FAIL irq_rise got %b want 1", timer_irq); end
      wr(2'd1, 32'd100);
      n_cmp++; if (irq_at_ack !== 1'b0) begin n_bad++; $display("FAIL irq_fall got %b want 0", irq_at_ack); end
      rd(2'd3, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL status_below got %h want 00000000", v); end
      wr(2'd1, 32'd0);
      rd(2'd3, v);
      n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL status_match got %h want 00000001", v); end
      n_cmp++; if (timer_irq !== 1'b1) begin n_bad++; $display("FAIL irq_reassert got %b want 1", timer_irq); end
   endtask

   task automatic test_byte_sel_and_collision;
      logic [31:0] v;
      logic [31:0] dummy;
      do_reset();
      bus(1'b1, 2'd1, 32'hAABB_CCDD, 4'b0010, dummy);
      rd(2'd1, v);
      n_cmp++; if (v !== 32'hFFFF_CCFF) begin n_bad++; $display("FAIL byte_sel got %h want ffffccff", v); end
      wr(2'd2, 32'h0000_0001);        // enable, prescale 0: tick every cycle
      wr(2'd0, 32'h0000_1234);        // ack edge A collides with a tick
      wr(2'd2, 32'h0000_0000);        // acks at A+2, last tick there
      rd(2'd0, v);
      n_cmp++; if (v !== 32'h0000_1236) begin n_bad++; $display("FAIL write_vs_tick got %h want 00001236", v); end
   endtask

   initial begin
      test_reset();
      test_ctrl_mask();
      test_reset_midcycle();
      test_back_to_back();
      test_enable();
      test_prescale();
      test_wrap();
      test_irq();
      test_byte_sel_and_collision();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/subservient_wb_timer.md
SUBSERVIENT_WB_TIMER -- requirements
Module: subservient_wb_timer

Interface
REQ-001 SHALL have parameter DEFAULT_PRESCALE, 8'd0, CTRL.prescale value after reset.
REQ-002 SHALL have parameter CMP_RESET, 32'hFFFF_FFFF, MTIMECMP value after reset.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all state on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_wb_adr, input, 32, byte address; only bits [3:2] decoded.
REQ-006 SHALL have port i_wb_dat, input, 32, write data.
REQ-007 SHALL have port i_wb_sel, input, 4, byte enables for writes.
REQ-008 SHALL have port i_wb_we, input, 1, write strobe qualifier.
REQ-009 SHALL have port i_wb_stb, input, 1, cycle request; held by initiator until ack.
REQ-010 SHALL have port o_wb_rdt, output, 32, read data, valid with o_wb_ack.
REQ-011 SHALL have port o_wb_ack, output, 1, single-cycle acknowledge.
REQ-012 SHALL have port o_timer_irq, output, 1, registered level interrupt to CPU.

Function
REQ-013 SHALL map registers by i_wb_adr[3:2]: 0 MTIME, 1 MTIMECMP, 2 CTRL, 3 STATUS.
REQ-014 SHALL define CTRL: bit0 enable, bit1 irq_en, bits[15:8] prescale; other bits read 0, writes ignored.
REQ-015 SHALL define STATUS read-only: bit0 = (MTIME >= MTIMECMP) unsigned; writes ignored.
REQ-016 SHALL assert o_wb_ack for exactly one cycle, one cycle after i_wb_stb sampled high while o_wb_ack low (ack <= stb & ~ack); back-to-back requests thus acked every other cycle.
REQ-017 SHALL perform register write in the same edge that asserts o_wb_ack, only bytes with i_wb_sel set.
REQ-018 SHALL register o_wb_rdt on the edge asserting ack, from pre-write register state; o_wb_rdt holds value otherwise.
REQ-019 SHALL keep a prescale counter: when enable=1, counts 0..prescale; on reaching prescale emits a one-cycle tick and returns to 0; prescale=0 ticks every cycle.
REQ-020 SHALL increment MTIME by 1 per tick, wrapping 32'hFFFF_FFFF -> 0 with no flag.
REQ-021 SHALL freeze MTIME and hold the prescale counter at 0 while enable=0.
REQ-022 SHALL clear the prescale counter on any CTRL write that changes prescale or enable.
REQ-023 SHALL give a bus write to MTIME priority over a same-cycle tick (written value stored, increment lost).
REQ-024 SHALL drive o_timer_irq <= irq_en & (MTIME >= MTIMECMP) evaluated on next-state values, so irq reflects a write or increment one cycle later.
REQ-025 SHALL deassert o_timer_irq the cycle after a MTIMECMP write making MTIMECMP > MTIME.

Reset
REQ-026 SHALL on i_rst_n low, asynchronously: MTIME=0, MTIMECMP=CMP_RESET, CTRL={DEFAULT_PRESCALE,6'b0,irq_en=0,enable=0}, prescale counter=0, o_wb_ack=0, o_wb_rdt=0, o_timer_irq=0.
REQ-027 SHALL drop an in-flight request on reset mid-cycle; initiator re-issues; no ack for it.

Structure
REQ-028 SHALL place register offsets, CTRL bit positions/field widths and STATUS bit in package subservient_timer_pkg.
REQ-029 SHALL implement the prescale counter and tick as sub-module subservient_timer_prescaler (inputs enable, prescale, clear; output tick).

Verification
REQ-030 SHALL cover: reset, read all four -> 0, CMP_RESET, 0, 0; o_timer_irq=0.
REQ-031 SHALL cover: write CTRL=32'h0000_0001, idle 10 cycles, read MTIME -> 10 ±1 documented ack offset, exact per REQ-016/019.
REQ-032 SHALL cover: prescale=3, enable=1, 40 cycles -> MTIME=10; change prescale mid-count -> counter restarts at 0.
REQ-033 SHALL cover: MTIME=32'hFFFF_FFFE, enable, prescale=0 -> reads 0 two ticks later.
REQ-034 SHALL cover: MTIMECMP=5, irq_en=1, enable -> o_timer_irq rises one cycle after MTIME reaches 5; write MTIMECMP=100 -> irq falls next cycle.
REQ-035 SHALL cover: sel=4'b0010 write 32'hAABBCCDD to MTIMECMP after reset -> reads FFFF_CCFF; MTIME write colliding with tick stores written value.
